// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter and the blocks that sit on the same memory.
package mem_arb_pkg;

    localparam int unsigned MEM_AW = 5;
    localparam int unsigned MEM_DW = 8;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_EXT = 1'b1
    } req_id_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-input round-robin picker: on a tie the requester that did not win last time wins.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);

    always_comb begin
        any    = |req;
        winner = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the CPU and the external loader, sequencing the fixed
// read latency and steering each read-return strobe back to the requester that issued it.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW      = MEM_AW,
    parameter int unsigned DW      = MEM_DW,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    arb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    req_id_e             last_gnt_q, last_gnt_d;
    req_id_e             rd_owner_q, rd_owner_d;
    logic [AW-1:0]       addr_q;
    logic [DW-1:0]       wdata_q;

    logic                win;
    logic                any;
    logic                can_gnt;
    req_id_e             win_id;
    logic                win_we;
    logic [AW-1:0]       win_addr;
    logic [DW-1:0]       win_wdata;

    arb_rr2 u_rr (
        .req    ({ext_req, cpu_req}),
        .last   (last_gnt_q == REQ_EXT),
        .winner (win),
        .any    (any)
    );

    // Grant/sequencing decision; the memory bus parks on the last issued access when idle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        rd_owner_d = rd_owner_q;
        cpu_gnt    = 1'b0;
        ext_gnt    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;

        win_id    = win ? REQ_EXT : REQ_CPU;
        win_we    = win ? ext_we    : cpu_we;
        win_addr  = win ? ext_addr  : cpu_addr;
        win_wdata = win ? ext_wdata : cpu_wdata;
        can_gnt   = (state_q == IDLE) || ((state_q == RD_WAIT) && (cnt_q == CNT_W'(1)));

        if (state_q == RD_WAIT) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = IDLE;
            end
        end

        if (can_gnt && any) begin
            last_gnt_d = win_id;
            cpu_gnt    = ~win;
            ext_gnt    = win;
            mem_addr   = win_addr;
            mem_wdata  = win_wdata;
            if (win_we) begin
                mem_write = 1'b1;
            end else begin
                // A latency of 4 loads 0 and wraps through 3,2,1, so 2 bits suffice.
                mem_read   = 1'b1;
                rd_owner_d = win_id;
                cnt_d      = CNT_W'(MEM_LAT);
                state_d    = RD_WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_gnt_q <= REQ_EXT;
            rd_owner_q <= REQ_CPU;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            rd_owner_q <= rd_owner_d;
            addr_q     <= mem_addr;
            wdata_q    <= mem_wdata;
        end
    end

    // Return strobes decode purely from registered state.
    assign busy       = (state_q == RD_WAIT);
    assign cpu_rvalid = busy && (cnt_q == CNT_W'(1)) && (rd_owner_q == REQ_CPU);
    assign ext_rvalid = busy && (cnt_q == CNT_W'(1)) && (rd_owner_q == REQ_EXT);
    assign cpu_rdata  = mem_rdata;
    assign ext_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at read latency 1 and one at latency 3
// share the same requester stimulus, each with its own memory model.
module tb_mem_arbiter;

    logic       clk;
    logic       rst;
    logic       cpu_req, cpu_we, ext_req, ext_we;
    logic [4:0] cpu_addr, ext_addr;
    logic [7:0] cpu_wdata, ext_wdata;

    logic       l1_cpu_gnt, l1_cpu_rvalid, l1_ext_gnt, l1_ext_rvalid;
    logic       l1_mem_read, l1_mem_write, l1_busy;
    logic [7:0] l1_cpu_rdata, l1_ext_rdata, l1_mem_wdata, l1_mem_rdata;
    logic [4:0] l1_mem_addr;
    logic       l3_cpu_gnt, l3_cpu_rvalid, l3_ext_gnt, l3_ext_rvalid;
    logic       l3_mem_read, l3_mem_write, l3_busy;
    logic [7:0] l3_cpu_rdata, l3_ext_rdata, l3_mem_wdata, l3_mem_rdata;
    logic [4:0] l3_mem_addr;

    int vec = 0;
    int err = 0;

    // Status order: {cpu_gnt, ext_gnt, mem_read, mem_write, busy, cpu_rvalid, ext_rvalid}
    logic [6:0] st1, st3;
    assign st1 = {l1_cpu_gnt, l1_ext_gnt, l1_mem_read, l1_mem_write, l1_busy, l1_cpu_rvalid, l1_ext_rvalid};
    assign st3 = {l3_cpu_gnt, l3_ext_gnt, l3_mem_read, l3_mem_write, l3_busy, l3_cpu_rvalid, l3_ext_rvalid};

    mem_arbiter #(.AW(5), .DW(8), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(l1_cpu_gnt), .cpu_rvalid(l1_cpu_rvalid), .cpu_rdata(l1_cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(l1_ext_gnt), .ext_rvalid(l1_ext_rvalid), .ext_rdata(l1_ext_rdata),
        .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_read(l1_mem_read),
        .mem_write(l1_mem_write), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
    );

    mem_arbiter #(.AW(5), .DW(8), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(l3_cpu_gnt), .cpu_rvalid(l3_cpu_rvalid), .cpu_rdata(l3_cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(l3_ext_gnt), .ext_rvalid(l3_ext_rvalid), .ext_rdata(l3_ext_rdata),
        .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata), .mem_read(l3_mem_read),
        .mem_write(l3_mem_write), .mem_rdata(l3_mem_rdata), .busy(l3_busy)
    );

    // Memory models: seeded on reset, read data delayed by the instance latency.
    logic [7:0] mem1 [32];
    logic [7:0] mem3 [32];
    logic [7:0] p1a, p3a, p3b, p3c;

    always @(posedge clk) begin
        if (!rst) begin
            mem1[5]  <= 8'h3C;
            mem1[31] <= 8'h00;
        end else if (l1_mem_write) begin
            mem1[l1_mem_addr] <= l1_mem_wdata;
        end
        p1a <= mem1[l1_mem_addr];
    end
    assign l1_mem_rdata = p1a;

    always @(posedge clk) begin
        if (!rst) begin
            mem3[4] <= 8'h44;
            mem3[7] <= 8'h5A;
            mem3[9] <= 8'h99;
        end else if (l3_mem_write) begin
            mem3[l3_mem_addr] <= l3_mem_wdata;
        end
        p3a <= mem3[l3_mem_addr];
        p3b <= p3a;
        p3c <= p3b;
    end
    assign l3_mem_rdata = p3c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 5'd0; cpu_wdata = 8'h00;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = 5'd0; ext_wdata = 8'h00;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        vec++; if (st1 !== 7'b0) begin err++; $display("FAIL reset_st1: got %b want %b", st1, 7'b0); end
        vec++; if (st3 !== 7'b0) begin err++; $display("FAIL reset_st3: got %b want %b", st3, 7'b0); end
        vec++; if ({l1_mem_addr, l1_mem_wdata, l3_mem_addr, l3_mem_wdata} !== 26'd0) begin
            err++; $display("FAIL reset_bus: got %h/%h %h/%h want 0", l1_mem_addr, l1_mem_wdata, l3_mem_addr, l3_mem_wdata);
        end
        tick();
    endtask

    task automatic test_cpu_read();
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
        @(negedge clk);
        vec++; if (st1 !== 7'b1010000) begin err++; $display("FAIL rd_gnt: got %b want %b", st1, 7'b1010000); end
        vec++; if (l1_mem_addr !== 5'd5) begin err++; $display("FAIL rd_addr: got %0d want 5", l1_mem_addr); end
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        vec++; if (st1 !== 7'b0000110) begin err++; $display("FAIL rd_rvalid: got %b want %b", st1, 7'b0000110); end
        vec++; if (l1_cpu_rdata !== 8'h3C) begin err++; $display("FAIL rd_data: got %h want 3c", l1_cpu_rdata); end
        tick();
        @(negedge clk);
        vec++; if (st1 !== 7'b0) begin err++; $display("FAIL rd_after: got %b want %b", st1, 7'b0); end
        vec++; if (l1_mem_addr !== 5'd5) begin err++; $display("FAIL rd_hold_addr: got %0d want 5", l1_mem_addr); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
        for (int i = 0; i < 3; i++) begin
            exp = (i == 0) ? 7'b1010000 : 7'b1010110;
            @(negedge clk);
            vec++; if (st1 !== exp) begin err++; $display("FAIL b2b_rd%0d: got %b want %b", i, st1, exp); end
            tick();
        end
        cpu_req = 1'b0;
        @(negedge clk);
        vec++; if (st1 !== 7'b0000110) begin err++; $display("FAIL b2b_last: got %b want %b", st1, 7'b0000110); end
        vec++; if (l1_cpu_rdata !== 8'h3C) begin err++; $display("FAIL b2b_data: got %h want 3c", l1_cpu_rdata); end
        tick();
        @(negedge clk);
        vec++; if (st1 !== 7'b0) begin err++; $display("FAIL b2b_idle: got %b want %b", st1, 7'b0); end
        tick();
    endtask

    task automatic test_alternate();
        logic [2:0] exp;
        logic [4:0] exp_addr;
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd1; cpu_wdata = 8'h11;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 5'd2; ext_wdata = 8'h22;
        for (int i = 0; i < 4; i++) begin
            exp      = (i % 2 == 0) ? 3'b101 : 3'b011;
            exp_addr = (i % 2 == 0) ? 5'd1 : 5'd2;
            @(negedge clk);
            vec++; if ({l1_cpu_gnt, l1_ext_gnt, l1_mem_write} !== exp) begin
                err++; $display("FAIL alt_gnt%0d: got %b want %b", i, {l1_cpu_gnt, l1_ext_gnt, l1_mem_write}, exp);
            end
            vec++; if (l1_mem_addr !== exp_addr) begin
                err++; $display("FAIL alt_addr%0d: got %0d want %0d", i, l1_mem_addr, exp_addr);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_lat3_pending();
        apply_reset();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 5'd7;
        @(negedge clk);
        vec++; if (st3 !== 7'b0110000) begin err++; $display("FAIL l3_gnt: got %b want %b", st3, 7'b0110000); end
        tick();
        ext_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd3; cpu_wdata = 8'h77;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            vec++; if (st3 !== 7'b0000100) begin err++; $display("FAIL l3_wait%0d: got %b want %b", i, st3, 7'b0000100); end
            tick();
        end
        @(negedge clk);
        vec++; if (st3 !== 7'b1001101) begin err++; $display("FAIL l3_rv_gnt: got %b want %b", st3, 7'b1001101); end
        vec++; if (l3_ext_rdata !== 8'h5A) begin err++; $display("FAIL l3_data: got %h want 5a", l3_ext_rdata); end
        vec++; if (l3_mem_addr !== 5'd3) begin err++; $display("FAIL l3_waddr: got %0d want 3", l3_mem_addr); end
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        vec++; if (st3 !== 7'b0) begin err++; $display("FAIL l3_idle: got %b want %b", st3, 7'b0); end
        tick();
    endtask

    task automatic test_reset_in_flight();
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd4;
        @(negedge clk);
        vec++; if (st3 !== 7'b1010000) begin err++; $display("FAIL rif_gnt: got %b want %b", st3, 7'b1010000); end
        tick();
        cpu_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        vec++; if (st3 !== 7'b0000100) begin err++; $display("FAIL rif_busy: got %b want %b", st3, 7'b0000100); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        vec++; if (st3 !== 7'b0) begin err++; $display("FAIL rif_cleared: got %b want %b", st3, 7'b0); end
        vec++; if ({l3_mem_addr, l3_mem_wdata} !== 13'd0) begin
            err++; $display("FAIL rif_bus: got %h/%h want 0", l3_mem_addr, l3_mem_wdata);
        end
        tick();
        for (int i = 3; i <= 4; i++) begin
            @(negedge clk);
            vec++; if (st3 !== 7'b0) begin err++; $display("FAIL rif_t%0d: got %b want %b", i, st3, 7'b0); end
            tick();
        end
    endtask

    task automatic test_withdraw();
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd9;
        @(negedge clk);
        vec++; if (st3 !== 7'b1010000) begin err++; $display("FAIL wd_gnt: got %b want %b", st3, 7'b1010000); end
        tick();
        cpu_req = 1'b0;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 5'd10; ext_wdata = 8'hEE;
        @(negedge clk);
        vec++; if (st3 !== 7'b0000100) begin err++; $display("FAIL wd_blip: got %b want %b", st3, 7'b0000100); end
        tick();
        ext_req = 1'b0;
        @(negedge clk);
        vec++; if (st3 !== 7'b0000100) begin err++; $display("FAIL wd_t2: got %b want %b", st3, 7'b0000100); end
        tick();
        @(negedge clk);
        vec++; if (st3 !== 7'b0000110) begin err++; $display("FAIL wd_rvalid: got %b want %b", st3, 7'b0000110); end
        vec++; if (l3_cpu_rdata !== 8'h99) begin err++; $display("FAIL wd_data: got %h want 99", l3_cpu_rdata); end
        tick();
        @(negedge clk);
        vec++; if (st3 !== 7'b0) begin err++; $display("FAIL wd_idle: got %b want %b", st3, 7'b0); end
        tick();
    endtask

    task automatic test_wrap();
        apply_reset();
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 5'd31; ext_wdata = 8'hA5;
        @(negedge clk);
        vec++; if (st1 !== 7'b0101000) begin err++; $display("FAIL wrap_wgnt: got %b want %b", st1, 7'b0101000); end
        vec++; if ({l1_mem_addr, l1_mem_wdata} !== {5'd31, 8'hA5}) begin
            err++; $display("FAIL wrap_wbus: got %0d/%h want 31/a5", l1_mem_addr, l1_mem_wdata);
        end
        tick();
        ext_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd31;
        @(negedge clk);
        vec++; if (st1 !== 7'b1010000) begin err++; $display("FAIL wrap_rgnt: got %b want %b", st1, 7'b1010000); end
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        vec++; if (st1 !== 7'b0000110) begin err++; $display("FAIL wrap_rvalid: got %b want %b", st1, 7'b0000110); end
        vec++; if (l1_cpu_rdata !== 8'hA5) begin err++; $display("FAIL wrap_data: got %h want a5", l1_cpu_rdata); end
        vec++; if (l1_ext_rdata !== 8'hA5) begin err++; $display("FAIL wrap_ext_data: got %h want a5", l1_ext_rdata); end
        tick();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_cpu_read();
        test_back_to_back();
        test_alternate();
        test_lat3_pending();
        test_reset_in_flight();
        test_withdraw();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer for the single shared instruction/data memory of the multi-cycle stack processor. It lets two requesters share the one memory port: the control unit/datapath (CPU) and an external loader/debug port (EXT). It grants one access at a time with two-way round-robin fairness, tracks the fixed read latency and routes read-return strobes back to the requester that issued the read. It sits between both requesters and the memory macro.

## Interface
- AW, 5: address width
- DW, 8: data width
- MEM_LAT, 1: memory read latency in cycles, legal range 1..4
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (rst=0 at a rising edge resets)
- cpu_req  in  1  CPU access request, held until granted (may be withdrawn before grant)
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  one-cycle pulse; CPU access issued to memory this cycle
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid
- cpu_rdata  out  DW  read data (mem_rdata pass-through)
- ext_req, ext_we, ext_addr, ext_wdata, ext_gnt, ext_rvalid, ext_rdata: same as cpu_* for EXT
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_read cycle
- busy  out  1  read outstanding (state RD_WAIT)

## Operation
- States: IDLE, RD_WAIT. Down-counter cnt, width 2 bits, sized for MEM_LAT ≤ 4. Registers: last_gnt (CPU/EXT) and rd_owner (CPU/EXT).
- Grant is possible when state=IDLE, or when state=RD_WAIT with cnt==1 (last wait cycle).
- Winner selection:
  - Only one requester asserted: it wins.
  - Both asserted: the one not equal to last_gnt wins.
  - On each grant, last_gnt <= winner.
- Grant cycle:
  - Assert the winner's gnt.
  - Drive mem_addr and mem_wdata from the winner.
  - Assert mem_write if we=1, else mem_read.
- Write grant: next state IDLE. Back-to-back writes are possible every cycle.
- Read grant:
  - rd_owner <= winner; cnt <= MEM_LAT; next state RD_WAIT.
  - In RD_WAIT, cnt decrements each cycle.
  - When cnt==1, assert the rd_owner's rvalid. Next state is IDLE, or RD_WAIT again if a new read is granted in that same cycle.
- cpu_rdata = ext_rdata = mem_rdata at all times. Only rvalid qualifies the data.
- With no grant: mem_read=mem_write=0, and mem_addr/mem_wdata hold their last value.
- Reset: state IDLE, cnt 0, last_gnt=EXT (CPU wins the first tie), rd_owner=CPU.
- Reset output values: all gnt/rvalid/mem_read/mem_write/busy 0, mem_addr 0, mem_wdata 0.
- Reset during RD_WAIT: the outstanding read is dropped and no rvalid is ever produced for it.
- Request withdrawn before grant: no effect, no state change.
- Request for the same requester while its own read is outstanding: not granted before the cnt==1 cycle.

## Timing
- Write: gnt at cycle t; memory written at the end of cycle t; no rvalid.
- Read: gnt and mem_read at cycle t; rvalid at t+MEM_LAT.
- Throughput:
  - Reads: one per MEM_LAT cycles.
  - MEM_LAT=1: a read may be granted every cycle.
- Grant decision is combinational from req/state in the same cycle. All state is registered.
- rvalid is decoded from registered state and cnt, so it is glitch-free relative to clk.

## Structure
- Package mem_arb_pkg holds:
  - the state enum {IDLE, RD_WAIT};
  - the requester id encoding (REQ_CPU=0, REQ_EXT=1);
  - default AW/DW constants shared with the memory and datapath.
- Sub-module arb_rr2: two-input round-robin picker (inputs req[1:0], last; outputs winner and any). It is reused by later shared-resource arbiters.

## Test plan
- Reset, then CPU read addr 5 with MEM_LAT=1 and mem[5]=8'h3C: cpu_gnt at t, cpu_rvalid at t+1 with cpu_rdata=8'h3C, ext_rvalid stays 0.
- cpu_req and ext_req held continuously, both writes to addrs 1 and 2: grants alternate CPU, EXT, CPU, EXT, one per cycle, starting with CPU.
- MEM_LAT=3, EXT read then CPU write pending:
  - ext_gnt at t, busy=1 for t+1..t+3;
  - ext_rvalid at t+3 and cpu_gnt at t+3 (same cycle);
  - no grant at t+1 or t+2.
- Read in flight (MEM_LAT=3), rst=0 at t+1: no rvalid at t+3; all outputs 0 the cycle after reset.
- ext_req asserted one cycle then dropped while a CPU read is outstanding: ext_gnt never asserts, and the memory sees no EXT access.
- Write 8'hA5 to addr 31 by EXT, then CPU read addr 31: cpu_rdata=8'hA5 at rvalid (checks address-width wrap boundary).
